// File: rtl/sii_ncu_xfer_chk.sv
// SII->NCU inbound protocol checker and transfer tracker (passive tap).
// Define SII_NCU_CHK_PLD_CAP_EN to build the payload capture registers.
module sii_ncu_xfer_chk #(
    parameter int DATA_W    = 32,
    parameter int PAR_W     = DATA_W / 16,
    parameter int PLD_BEATS = 4,
    parameter int TMO_CYC   = 1024,
    parameter int CNT_W     = 16
) (
    input  logic                        iol2clk,
    input  logic                        rst_l,
    input  logic                        sii_ncu_req,
    input  logic                        ncu_sii_gnt,
    input  logic [DATA_W-1:0]           sii_ncu_data,
    input  logic [PAR_W-1:0]            sii_ncu_dparity,
    input  logic                        err_clr,
    output logic                        busy,
    output logic                        xfer_done,
    output logic [2:0]                  hdr_cmd,
    output logic [3:0]                  hdr_tag,
    output logic [8:0]                  hdr_info,
    output logic [DATA_W*PLD_BEATS-1:0] pld_data,
    output logic [CNT_W-1:0]            xfer_cnt,
    output logic [4:0]                  err_status
);

    localparam int TMO_W  = $clog2(TMO_CYC + 1);
    localparam int BEAT_W = (PLD_BEATS > 1) ? $clog2(PLD_BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HDR,
        PLD
    } state_t;

    state_t            state;
    logic [BEAT_W-1:0] beat;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              par_err;
    logic              last_beat;
    logic              wait_hold;
    logic [4:0]        err_set;

    always_comb begin
        par_err = 1'b0;
        for (int i = 0; i < PAR_W; i++) begin
            if (sii_ncu_dparity[i] != ^sii_ncu_data[16*i +: 16]) par_err = 1'b1;
        end
    end

    assign busy      = (state == HDR) || (state == PLD);
    assign last_beat = (state == PLD) && (beat == BEAT_W'(PLD_BEATS - 1));
    assign xfer_done = last_beat;
    assign wait_hold = (state == WAIT) && sii_ncu_req && !ncu_sii_gnt;

    // A grant with no request pending counts as err[1] whether idle or the request just dropped.
    always_comb begin
        err_set    = '0;
        err_set[0] = busy && par_err;
        err_set[1] = ((state == IDLE) || (state == WAIT)) && !sii_ncu_req && ncu_sii_gnt;
        err_set[2] = busy && ncu_sii_gnt;
        err_set[3] = (state == WAIT) && !sii_ncu_req;
        err_set[4] = wait_hold && (tmo_cnt == TMO_W'(TMO_CYC - 1));
    end

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            state      <= IDLE;
            beat       <= '0;
            tmo_cnt    <= '0;
            hdr_cmd    <= '0;
            hdr_tag    <= '0;
            hdr_info   <= '0;
            xfer_cnt   <= '0;
            err_status <= '0;
        end else begin
            err_status <= (err_clr ? 5'b0 : err_status) | err_set;

            if (wait_hold) begin
                if (tmo_cnt != TMO_W'(TMO_CYC)) tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end

            unique case (state)
                IDLE: begin
                    if (sii_ncu_req && ncu_sii_gnt) state <= HDR;
                    else if (sii_ncu_req) state <= WAIT;
                end
                WAIT: begin
                    if (!sii_ncu_req) state <= IDLE;
                    else if (ncu_sii_gnt) state <= HDR;
                end
                HDR: begin
                    hdr_cmd  <= sii_ncu_data[15:13];
                    hdr_tag  <= sii_ncu_data[12:9];
                    hdr_info <= sii_ncu_data[8:0];
                    beat     <= '0;
                    state    <= PLD;
                end
                PLD: begin
                    if (last_beat) begin
                        state <= IDLE;
                        if (xfer_cnt != '1) xfer_cnt <= xfer_cnt + 1'b1;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SII_NCU_CHK_PLD_CAP_EN
    logic [DATA_W*PLD_BEATS-1:0] pld_q;

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            pld_q <= '0;
        end else if (state == PLD) begin
            pld_q[beat*DATA_W +: DATA_W] <= sii_ncu_data;
        end
    end

    assign pld_data = pld_q;
`else
    assign pld_data = '0;
`endif

endmodule

// File: tb/tb_sii_ncu_xfer_chk.sv
// Randomised and directed bench for sii_ncu_xfer_chk against a beat-count reference model.
module tb_sii_ncu_xfer_chk;

    localparam int DW   = 32;
    localparam int PB   = 4;
    localparam int TMO  = 8;
    localparam int CW   = 3;
    localparam int CMAX = 7;

    logic          clk = 1'b0;
    logic          rst_l;
    logic          req, gnt, clr;
    logic [31:0]   data;
    logic [1:0]    dpar;
    logic          busy, xfer_done;
    logic [2:0]    hdr_cmd;
    logic [3:0]    hdr_tag;
    logic [8:0]    hdr_info;
    logic [127:0]  pld_data;
    logic [CW-1:0] xfer_cnt;
    logic [4:0]    err_status;

    sii_ncu_xfer_chk #(
        .DATA_W(DW), .PAR_W(2), .PLD_BEATS(PB), .TMO_CYC(TMO), .CNT_W(CW)
    ) dut (
        .iol2clk(clk), .rst_l(rst_l), .sii_ncu_req(req), .ncu_sii_gnt(gnt),
        .sii_ncu_data(data), .sii_ncu_dparity(dpar), .err_clr(clr),
        .busy(busy), .xfer_done(xfer_done), .hdr_cmd(hdr_cmd), .hdr_tag(hdr_tag),
        .hdr_info(hdr_info), .pld_data(pld_data), .xfer_cnt(xfer_cnt),
        .err_status(err_status)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // reference model: m_beat = -1 no transfer, 0 header, 1..PB payload beat
    int          m_beat;
    bit          m_wait;
    int          m_wcnt;
    logic [4:0]  m_err;
    int          m_cnt;
    logic [15:0] m_hdr;
    logic [127:0] m_pld;
    bit          e_done, e_busy, o_done, o_busy;
    int          t_step = 0;
    int          done_hits, done_step;
    logic [31:0] pv [PB];

    typedef struct packed {
        logic        r;
        logic        g;
        logic [31:0] d;
        logic [1:0]  p;
        logic        c;
    } stim_t;

    function automatic logic [1:0] gp(input logic [31:0] d);
        return {^d[31:16], ^d[15:0]};
    endfunction

    task automatic model_reset();
        m_beat = -1; m_wait = 0; m_wcnt = 0; m_err = '0;
        m_cnt = 0; m_hdr = '0; m_pld = '0;
    endtask

    task automatic step(input logic r, input logic g, input logic [31:0] d,
                        input logic [1:0] p, input logic c);
        logic [4:0] ne;
        @(negedge clk);
        req = r; gnt = g; data = d; dpar = p; clr = c;
        #1;
        o_done = xfer_done;
        o_busy = busy;
        e_busy = (m_beat >= 0);
        e_done = (m_beat == PB);
        if (o_done) begin
            done_hits++;
            done_step = t_step;
        end
        t_step++;
        @(posedge clk);
        ne = '0;
        if (m_beat >= 0) begin
            if (p != gp(d)) ne[0] = 1'b1;
            if (g) ne[2] = 1'b1;
            if (m_beat == 0) m_hdr = d[15:0];
`ifdef SII_NCU_CHK_PLD_CAP_EN
            else m_pld[(m_beat-1)*32 +: 32] = d;
`endif
            if (m_beat == PB) begin
                m_beat = -1;
                if (m_cnt < CMAX) m_cnt++;
            end else begin
                m_beat++;
            end
        end else if (m_wait) begin
            if (!r) begin
                ne[3] = 1'b1;
                if (g) ne[1] = 1'b1;
                m_wait = 0;
            end else if (g) begin
                m_wait = 0;
                m_beat = 0;
            end else if (m_wcnt < TMO) begin
                m_wcnt++;
                if (m_wcnt == TMO) ne[4] = 1'b1;
            end
        end else begin
            if (r && g) m_beat = 0;
            else if (r) begin
                m_wait = 1;
                m_wcnt = 0;
            end else if (g) ne[1] = 1'b1;
        end
        m_err = (c ? 5'b0 : m_err) | ne;
        #1;
    endtask

    task automatic do_xfer(input int w, input logic [15:0] hdr,
                           input int bad_beat, input int gnt_beat);
        logic [1:0] p;
        for (int i = 0; i < w; i++) step(1, 0, $urandom, 2'b00, 0);
        step(1, 1, 32'h0, 2'b00, 0);
        step(0, 0, {16'h0, hdr}, gp({16'h0, hdr}), 0);
        for (int b = 0; b < PB; b++) begin
            p = gp(pv[b]);
            if (b == bad_beat) p[1] = ~p[1];
            step(0, (b == gnt_beat), pv[b], p, 0);
        end
    endtask

    task automatic test_reset();
        rst_l = 1'b0; req = 0; gnt = 0; clr = 0; data = '0; dpar = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if ({busy, xfer_done, hdr_cmd, hdr_tag, hdr_info, xfer_cnt, err_status} !== '0
            || pld_data !== '0) begin
            nerr++;
            $display("FAIL reset_outputs got busy=%b cnt=%0d err=%b hdr=%h want all 0",
                     busy, xfer_cnt, err_status, {hdr_cmd, hdr_tag, hdr_info});
        end
        @(negedge clk);
        rst_l = 1'b1;
    endtask

    task automatic test_basic();
        int t0;
        pv[0] = 32'h0BAD_F00D; pv[1] = 32'h1234_5678;
        pv[2] = 32'h9ABC_DEF0; pv[3] = 32'hCAFE_BEEF;
        done_hits = 0;
        t0 = t_step;
        do_xfer(3, 16'hA5F3, -1, -1);
        nvec++;
        if ({hdr_cmd, hdr_tag, hdr_info} !== {3'd5, 4'd2, 9'h1F3}) begin
            nerr++;
            $display("FAIL basic_hdr got %0d/%0d/%h want 5/2/1f3", hdr_cmd, hdr_tag, hdr_info);
        end
        nvec++;
        if (done_hits != 1 || done_step - t0 != 8) begin
            nerr++;
            $display("FAIL basic_done_timing got hits=%0d at t%0d want 1 at t8",
                     done_hits, done_step - t0);
        end
        nvec++;
        if (xfer_cnt !== 3'd1 || err_status !== 5'b0) begin
            nerr++;
            $display("FAIL basic_cnt_err got cnt=%0d err=%b want 1 00000", xfer_cnt, err_status);
        end
    endtask

    task automatic test_parity_clr();
        do_xfer(3, 16'hA5F3, 2, -1);
        nvec++;
        if (err_status !== 5'b00001 || xfer_cnt !== 3'd2) begin
            nerr++;
            $display("FAIL parity_err got err=%b cnt=%0d want 00001 2", err_status, xfer_cnt);
        end
        step(0, 0, 32'h0, 2'b00, 1);
        nvec++;
        if (err_status !== 5'b0) begin
            nerr++;
            $display("FAIL parity_clr got err=%b want 00000", err_status);
        end
    endtask

    task automatic test_gnt_errors();
        int t0;
        step(0, 1, 32'h0, 2'b00, 0);
        nvec++;
        if (err_status !== 5'b00010) begin
            nerr++;
            $display("FAIL gnt_no_req got err=%b want 00010", err_status);
        end
        // clear and a fresh error in the same cycle: the new error must survive
        step(0, 1, 32'h0, 2'b00, 1);
        nvec++;
        if (err_status !== 5'b00010) begin
            nerr++;
            $display("FAIL clr_set_wins got err=%b want 00010", err_status);
        end
        step(0, 0, 32'h0, 2'b00, 1);
        done_hits = 0;
        t0 = t_step;
        do_xfer(2, 16'h1234, -1, 1);
        nvec++;
        if (err_status !== 5'b00100) begin
            nerr++;
            $display("FAIL gnt_busy got err=%b want 00100", err_status);
        end
        nvec++;
        if (done_hits != 1 || done_step - t0 != 7) begin
            nerr++;
            $display("FAIL gnt_busy_timing got hits=%0d at t%0d want 1 at t7",
                     done_hits, done_step - t0);
        end
        step(0, 0, 32'h0, 2'b00, 1);
    endtask

    task automatic test_timeout();
        for (int k = 1; k <= 20; k++) begin
            step(1, 0, $urandom, 2'b11, 0);
            nvec++;
            if (err_status[4] !== (k - 1 >= TMO) || busy !== 1'b0) begin
                nerr++;
                $display("FAIL timeout_k%0d got err4=%b busy=%b want %b 0",
                         k, err_status[4], busy, (k - 1 >= TMO));
            end
        end
        step(0, 0, 32'h0, 2'b00, 0);
        nvec++;
        if (err_status !== 5'b11000) begin
            nerr++;
            $display("FAIL req_drop got err=%b want 11000", err_status);
        end
        step(0, 0, 32'h0, 2'b00, 0);
        nvec++;
        if (o_busy !== 1'b0 || m_err !== err_status) begin
            nerr++;
            $display("FAIL after_drop got busy=%b err=%b want 0 %b", o_busy, err_status, m_err);
        end
        step(0, 0, 32'h0, 2'b00, 1);
    endtask

    task automatic test_reset_mid();
        logic ok;
        pv[0] = 32'h1; pv[1] = 32'h2; pv[2] = 32'h3; pv[3] = 32'h4;
        step(1, 1, 32'h0, 2'b00, 0);
        step(0, 0, 32'h0000_FFFF, gp(32'h0000_FFFF), 0);
        step(0, 0, pv[0], gp(pv[0]), 0);
        @(negedge clk);
        data = pv[1]; dpar = gp(pv[1]);
        #1 rst_l = 1'b0;
        #1;
        ok = ({busy, xfer_done, hdr_cmd, hdr_tag, hdr_info, xfer_cnt, err_status} === '0)
             && (pld_data === '0);
        @(posedge clk);
        #1 ok = ok && (xfer_done === 1'b0) && (busy === 1'b0);
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL reset_mid got busy=%b done=%b cnt=%0d hdr=%h want all 0",
                     busy, xfer_done, xfer_cnt, {hdr_cmd, hdr_tag, hdr_info});
        end
        @(negedge clk);
        rst_l = 1'b1;
        model_reset();
        done_hits = 0;
        do_xfer(1, 16'hFFFF, -1, -1);
        nvec++;
        if (xfer_cnt !== 3'd1 || done_hits != 1) begin
            nerr++;
            $display("FAIL reset_then_xfer got cnt=%0d hits=%0d want 1 1", xfer_cnt, done_hits);
        end
    endtask

    task automatic test_payload();
        logic [127:0] want;
        pv[0] = 32'h1111_1111; pv[1] = 32'h2222_2222;
        pv[2] = 32'h3333_3333; pv[3] = 32'h4444_4444;
        do_xfer(0, 16'h0203, -1, -1);
`ifdef SII_NCU_CHK_PLD_CAP_EN
        want = 128'h44444444_33333333_22222222_11111111;
`else
        want = '0;
`endif
        nvec++;
        if (pld_data !== want || pld_data !== m_pld) begin
            nerr++;
            $display("FAIL payload got %h want %h", pld_data, want);
        end
    endtask

    task automatic test_random();
        stim_t q[$];
        stim_t s;
        int    w;
        logic [31:0] d;
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < int'($urandom % 3); i++) begin
                d = $urandom;
                q.push_back('{1'b0, ($urandom % 8 == 0), d, gp(d), ($urandom % 10 == 0)});
            end
            w = $urandom % 12;
            for (int i = 0; i < w; i++) begin
                d = $urandom;
                q.push_back('{1'b1, 1'b0, d, 2'($urandom), ($urandom % 10 == 0)});
            end
            if ($urandom % 10 == 0) begin
                q.push_back('{1'b0, 1'b0, 32'h0, 2'b00, 1'b0});
                continue;
            end
            q.push_back('{1'b1, 1'b1, 32'h0, 2'b00, 1'b0});
            for (int b = 0; b <= PB; b++) begin
                d = $urandom;
                q.push_back('{1'b0, ($urandom % 8 == 0), d,
                              gp(d) ^ (($urandom % 6 == 0) ? 2'($urandom) : 2'b00),
                              ($urandom % 10 == 0)});
            end
        end
        while (q.size() > 0) begin
            s = q.pop_front();
            step(s.r, s.g, s.d, s.p, s.c);
            nvec++;
            if (o_busy !== e_busy || o_done !== e_done) begin
                nerr++;
                $display("FAIL rand_busy_done t%0d got %b%b want %b%b",
                         t_step, o_busy, o_done, e_busy, e_done);
            end
            nvec++;
            if ({hdr_cmd, hdr_tag, hdr_info} !== m_hdr || pld_data !== m_pld) begin
                nerr++;
                $display("FAIL rand_hdr_pld t%0d got %h/%h want %h/%h",
                         t_step, {hdr_cmd, hdr_tag, hdr_info}, pld_data, m_hdr, m_pld);
            end
            nvec++;
            if (xfer_cnt !== CW'(m_cnt) || err_status !== m_err) begin
                nerr++;
                $display("FAIL rand_cnt_err t%0d got %0d/%b want %0d/%b",
                         t_step, xfer_cnt, err_status, m_cnt, m_err);
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 10; i++) do_xfer(0, 16'h0, -1, -1);
        nvec++;
        if (xfer_cnt !== 3'd7) begin
            nerr++;
            $display("FAIL cnt_saturate got %0d want 7", xfer_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity_clr();
        test_gnt_errors();
        test_timeout();
        test_reset_mid();
        test_payload();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
